// File: rtl/alu_pkg.sv
// Shared constants for the sequential ALU: default width, opcodes, FSM states.
package alu_pkg;

  localparam int unsigned N_DEFAULT = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/booth_mul_seq.sv
// Iterative radix-2 Booth multiplier: one recoding step per cycle, W steps.
// done/product are combinational on the final step so the caller can capture
// the product on the same edge that retires the last iteration.
module booth_mul_seq #(
  parameter int unsigned W = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] product
);

  // {upper (W+1, one guard bit), multiplier (W), booth bit q(-1)}
  localparam int unsigned PW = 2*W + 2;
  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  logic [PW-1:0] r_acc;
  logic [W:0]    r_m;
  logic [CW-1:0] r_cnt;
  logic          r_busy;

  logic [W:0]    w_upper;
  logic [PW-1:0] w_next;

  // One Booth step: add/subtract multiplicand per bit pair, then arithmetic shift.
  always_comb begin
    w_upper = r_acc[PW-1 -: W+1];
    case (r_acc[1:0])
      2'b01:   w_upper = r_acc[PW-1 -: W+1] + r_m;
      2'b10:   w_upper = r_acc[PW-1 -: W+1] - r_m;
      default: w_upper = r_acc[PW-1 -: W+1];
    endcase
    w_next = {w_upper[W], w_upper, r_acc[W:1]};
  end

  assign done    = r_busy && (r_cnt == CW'(W-1));
  assign product = w_next[2*W:1];

  // Load on start, then iterate until the final step has been applied.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc  <= '0;
      r_m    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (start) begin
      r_acc  <= {{(W+1){1'b0}}, b, 1'b0};
      r_m    <= {a[W-1], a};
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_acc <= w_next;
      if (done) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_alu_core.sv
// Sequential ALU: single-cycle add/sub/logic, W-cycle Booth multiply,
// valid/ready handshake on both sides.
module seq_alu_core
  import alu_pkg::*;
#(
  parameter  int unsigned N = N_DEFAULT,
  localparam int unsigned W = N + 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [W-1:0]   A,
  input  logic [W-1:0]   B,
  input  logic [2:0]     op,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [2*W-1:0] R,
  output logic           err,
  output logic           out_valid,
  input  logic           out_ready
);

  state_e         r_state;
  logic [2*W-1:0] r_R;
  logic           r_err;

  logic           w_accept;
  logic           w_illegal;
  logic [W-1:0]   w_res;
  logic           w_mul_start;
  logic           w_mul_done;
  logic [2*W-1:0] w_mul_prod;

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign R           = r_R;
  assign err         = r_err;
  assign w_accept    = in_valid && (r_state == S_IDLE);
  assign w_mul_start = w_accept && (op == OP_MUL);

  // Single-cycle datapath evaluated on the accepting edge's operands.
  always_comb begin
    w_res     = '0;
    w_illegal = 1'b0;
    case (op)
      OP_ADD:  w_res = A + B;
      OP_SUB:  w_res = A - B;
      OP_AND:  w_res = A & B;
      OP_OR:   w_res = A | B;
      OP_XOR:  w_res = A ^ B;
      OP_MUL:  w_res = '0;
      default: w_illegal = 1'b1;
    endcase
  end

  booth_mul_seq #(.W(W)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (w_mul_start),
    .a       (A),
    .b       (B),
    .done    (w_mul_done),
    .product (w_mul_prod)
  );

  // Control FSM with registered result and error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_R     <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (op == OP_MUL) begin
              r_state <= S_CALC;
              r_err   <= 1'b0;
            end else begin
              r_state <= S_DONE;
              r_R     <= w_illegal ? '0 : {{W{w_res[W-1]}}, w_res};
              r_err   <= w_illegal;
            end
          end
        end
        S_CALC: begin
          if (w_mul_done) begin
            r_R     <= w_mul_prod;
            r_err   <= 1'b0;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu_core.sv
// Directed bench for seq_alu_core at N=4 (W=6): vector table plus
// back-pressure and reset-abort sequences.
module tb_seq_alu_core;

  localparam int unsigned N = 4;
  localparam int unsigned W = N + 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic [2:0]     op;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] R;
  logic           err;
  logic           out_valid;
  logic           out_ready;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [2:0]  op;
    logic [5:0]  a;
    logic [5:0]  b;
    logic [11:0] r;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  seq_alu_core #(.N(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .A         (A),
    .B         (B),
    .op        (op),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .R         (R),
    .err       (err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one request, measure latency to out_valid, check result, then consume it.
  task automatic run_vec(input vec_t v, input string name);
    int  c;
    bit  got;
    @(negedge clk);
    c = 0;
    while (!in_ready && c < 20) begin
      @(negedge clk);
      c++;
    end
    check({name, " in_ready"}, 32'(in_ready), 32'd1);
    op = v.op; A = v.a; B = v.b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    c   = 1;
    got = out_valid;
    while (!got && c < 30) begin
      @(negedge clk);
      c++;
      got = out_valid;
    end
    check({name, " latency"}, got ? 32'(c) : 32'd0, 32'(v.lat));
    check({name, " R"}, 32'(R), 32'(v.r));
    check({name, " err"}, 32'(err), 32'(v.err));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    bit stale;
    int c;

    //          op      a      b      r       err lat
    vecs[0]  = '{3'b000, 6'h07, 6'h07, 12'h00E, 1'b0, 1};
    vecs[1]  = '{3'b001, 6'h38, 6'h07, 12'hFF1, 1'b0, 1};
    vecs[2]  = '{3'b010, 6'h38, 6'h38, 12'h040, 1'b0, 7};
    vecs[3]  = '{3'b010, 6'h07, 6'h38, 12'hFC8, 1'b0, 7};
    vecs[4]  = '{3'b011, 6'h05, 6'h03, 12'h001, 1'b0, 1};
    vecs[5]  = '{3'b100, 6'h38, 6'h03, 12'hFFB, 1'b0, 1};
    vecs[6]  = '{3'b101, 6'h05, 6'h3F, 12'hFFA, 1'b0, 1};
    vecs[7]  = '{3'b111, 6'h05, 6'h03, 12'h000, 1'b1, 1};
    vecs[8]  = '{3'b000, 6'h38, 6'h38, 12'hFF0, 1'b0, 1};
    vecs[9]  = '{3'b110, 6'h3F, 6'h3F, 12'h000, 1'b1, 1};
    vecs[10] = '{3'b010, 6'h3F, 6'h3F, 12'h001, 1'b0, 7};
    vecs[11] = '{3'b010, 6'h07, 6'h07, 12'h031, 1'b0, 7};
    vecs[12] = '{3'b001, 6'h03, 6'h38, 12'h00B, 1'b0, 1};
    vecs[13] = '{3'b010, 6'h00, 6'h38, 12'h000, 1'b0, 7};

    reset = 1'b1; A = '0; B = '0; op = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset R", 32'(R), 32'd0);
    check("reset err", 32'(err), 32'd0);

    for (int i = 0; i < 14; i++)
      run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-pressure: ADD 3+4 held for 5 cycles with a competing request present.
    @(negedge clk);
    op = 3'b000; A = 6'h03; B = 6'h04; in_valid = 1'b1;
    @(negedge clk);
    check("hold first out_valid", 32'(out_valid), 32'd1);
    op = 3'b000; A = 6'h01; B = 6'h01; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("hold%0d R", k), 32'(R), 32'h007);
      check($sformatf("hold%0d out_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("hold%0d in_ready", k), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release out_valid", 32'(out_valid), 32'd0);
    check("release in_ready", 32'(in_ready), 32'd1);
    check("release R", 32'(R), 32'h007);
    in_valid = 1'b0;

    // Reset during the 3rd CALC cycle of a multiply.
    @(negedge clk);
    op = 3'b010; A = 6'h07; B = 6'h07; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("calc1 in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    @(negedge clk);
    check("calc3 out_valid", 32'(out_valid), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort out_valid", 32'(out_valid), 32'd0);
    check("abort R", 32'(R), 32'd0);
    check("abort err", 32'(err), 32'd0);
    check("abort in_ready", 32'(in_ready), 32'd1);
    stale = 1'b0;
    c = 0;
    while (c < 12) begin
      @(negedge clk);
      if (out_valid || R != '0) stale = 1'b1;
      c++;
    end
    check("abort no stale result", 32'(stale), 32'd0);

    run_vec('{3'b000, 6'h3F, 6'h02, 12'h001, 1'b0, 1}, "post-abort add");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
